// File: rtl/while_pkg.sv
// Shared types and elaboration helpers for the WhileEnt inverse (restoring divider).
package while_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Divisor used by the forward datapath: the loop body runs COUNT+1 times.
  function automatic int k_of(input int count);
    return count + 1;
  endfunction

  // K must fit in W bits and be nonzero; W >= 2 keeps the quotient shift well-formed.
  function automatic bit count_legal(input int count, input int w);
    return (w >= 2) && (w <= 30) && (count >= 0) && (count <= (1 << w) - 2);
  endfunction

endpackage

// File: rtl/while_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract K if it fits.
module while_div_step #(
  parameter int W = 8
) (
  input  logic [W:0]   i_rem,
  input  logic         i_bit,
  input  logic [W-1:0] i_k,
  output logic [W:0]   o_rem,
  output logic         o_q_bit
);

  logic [W+1:0] w_r;

  assign w_r = {i_rem, i_bit};

  always_comb begin
    o_rem   = w_r[W:0];
    o_q_bit = 1'b0;
    if (w_r >= (W+2)'(i_k)) begin
      // The difference is below K, so it always fits the W+1 bit remainder.
      o_rem   = (W+1)'(w_r - (W+2)'(i_k));
      o_q_bit = 1'b1;
    end
  end

endmodule

// File: rtl/while_inv.sv
// Recovers A from XOUT/B: S = XIN+B (wrapping), then S/K and S%K over W restoring steps.
module while_inv
  import while_pkg::*;
#(
  parameter int W     = 8,
  parameter int COUNT = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [W-1:0] XIN,
  input  logic [W-1:0] B,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [W-1:0] A_OUT,
  output logic [W-1:0] REM,
  output logic         EXACT
);

  localparam bit          COUNT_OK = count_legal(COUNT, W);
  localparam logic [W-1:0] K       = W'(k_of(COUNT));
  localparam int          CW       = $clog2(W);

  generate
    if (!COUNT_OK) begin : g_bad_count
      $error("while_inv: COUNT must satisfy 0 <= COUNT <= 2**W-2");
    end
  endgenerate

  state_t         r_state;
  state_t         w_state_next;
  logic [W-1:0]   r_s;
  logic [W:0]     r_rem;
  logic [W-1:0]   r_quo;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_a_out;
  logic [W-1:0]   r_rem_out;
  logic           r_exact;
  logic [W:0]     w_rem_next;
  logic           w_q_bit;
  logic [W-1:0]   w_quo_next;

  while_div_step #(.W(W)) u_step (
    .i_rem   (r_rem),
    .i_bit   (r_s[W-1]),
    .i_k     (K),
    .o_rem   (w_rem_next),
    .o_q_bit (w_q_bit)
  );

  assign w_quo_next = W'({r_quo, w_q_bit});

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (IN_VALID)       w_state_next = CALC;
      CALC:    if (r_cnt == '0)    w_state_next = DONE;
      DONE:    if (OUT_READY)      w_state_next = IDLE;
      default:                     w_state_next = IDLE;
    endcase
  end

  assign IN_READY  = (r_state == IDLE);
  assign OUT_VALID = (r_state == DONE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s       <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
      r_a_out   <= '0;
      r_rem_out <= '0;
      r_exact   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (IN_VALID) begin
            r_s   <= XIN + B;
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= CW'(W - 1);
          end
        end
        CALC: begin
          r_s   <= r_s << 1;
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            // Results are only published on the final step so they stay stable otherwise.
            r_a_out   <= w_quo_next;
            r_rem_out <= w_rem_next[W-1:0];
            r_exact   <= (w_rem_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign A_OUT = r_a_out;
  assign REM   = r_rem_out;
  assign EXACT = r_exact;

endmodule

// File: tb/tb_while_inv.sv
// Directed and swept checks of while_inv with K=5, K=1 and K=255 running in lockstep.
module tb_while_inv;

  logic       CLK = 1'b0;
  logic       RST;
  logic       IN_VALID;
  logic       OUT_READY;
  logic [7:0] XIN;
  logic [7:0] B;
  logic       ir [3];
  logic       ov [3];
  logic       ex [3];
  logic [7:0] ao [3];
  logic [7:0] rm [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  while_inv #(.W(8), .COUNT(4)) u_k5 (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(ir[0]), .XIN(XIN), .B(B),
    .OUT_VALID(ov[0]), .OUT_READY(OUT_READY), .A_OUT(ao[0]), .REM(rm[0]), .EXACT(ex[0])
  );
  while_inv #(.W(8), .COUNT(0)) u_k1 (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(ir[1]), .XIN(XIN), .B(B),
    .OUT_VALID(ov[1]), .OUT_READY(OUT_READY), .A_OUT(ao[1]), .REM(rm[1]), .EXACT(ex[1])
  );
  while_inv #(.W(8), .COUNT(254)) u_k255 (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(ir[2]), .XIN(XIN), .B(B),
    .OUT_VALID(ov[2]), .OUT_READY(OUT_READY), .A_OUT(ao[2]), .REM(rm[2]), .EXACT(ex[2])
  );

  typedef struct {
    logic [7:0] x;
    logic [7:0] b;
    logic [7:0] a5;
    logic [7:0] r5;
    logic [7:0] a255;
    logic [7:0] r255;
  } vec_t;

  // Hand-computed: S=35,4,255,1 divided by 5 and by 255.
  vec_t vecs [4] = '{
    '{8'd32,  8'd3,  8'd7,  8'd0, 8'd0, 8'd35},
    '{8'd250, 8'd10, 8'd0,  8'd4, 8'd0, 8'd4},
    '{8'd255, 8'd0,  8'd51, 8'd0, 8'd1, 8'd0},
    '{8'd0,   8'd1,  8'd0,  8'd1, 8'd0, 8'd1}
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic xfer(input logic [7:0] x, input logic [7:0] b,
                      input logic [7:0] a5, input logic [7:0] r5,
                      input logic [7:0] a255, input logic [7:0] r255,
                      input int hold);
    logic [7:0] s;
    int n;
    s = x + b;
    check("in_ready", ir[0], 1);
    XIN = x; B = b; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0; XIN = ~x; B = ~b;
    n = 0;
    while (!ov[0] && n < 20) begin
      if (hold > 0) begin
        IN_VALID = n[0];
        XIN      = 8'hAA;
      end
      tick();
      n++;
    end
    IN_VALID = 1'b0;
    check("latency", n, 8);
    check("calc_in_ready", ir[0], 0);
    check("k1_valid", ov[1], 1);
    check("k255_valid", ov[2], 1);
    check("k5_a", ao[0], a5);
    check("k5_rem", rm[0], r5);
    check("k5_exact", ex[0], (r5 == 0));
    check("k1_a", ao[1], s);
    check("k1_rem", rm[1], 0);
    check("k1_exact", ex[1], 1);
    check("k255_a", ao[2], a255);
    check("k255_rem", rm[2], r255);
    check("k255_exact", ex[2], (r255 == 0));
    $display("xfer x=%0d b=%0d: k5 a=%0d r=%0d, k1 a=%0d, k255 a=%0d r=%0d",
             x, b, ao[0], rm[0], ao[1], ao[2], rm[2]);
    for (int i = 0; i < hold; i++) begin
      IN_VALID = 1'b1;
      XIN      = 8'($urandom);
      tick();
      check("hold_valid", ov[0], 1);
      check("hold_in_ready", ir[0], 0);
      check("hold_a", ao[0], a5);
      check("hold_rem", rm[0], r5);
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    check("rel_valid", ov[0], 0);
    check("rel_in_ready", ir[0], 1);
  endtask

  initial begin
    int seen;
    logic [7:0] x, b, s;

    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; XIN = '0; B = '0;
    tick(); tick();
    RST = 1'b0;
    check("rst_in_ready", ir[0], 1);
    check("rst_valid", ov[0], 0);
    check("rst_a", ao[0], 0);
    check("rst_rem", rm[0], 0);
    check("rst_exact", ex[0], 0);

    foreach (vecs[i])
      xfer(vecs[i].x, vecs[i].b, vecs[i].a5, vecs[i].r5, vecs[i].a255, vecs[i].r255, 0);

    // Backpressure with noise on IN_VALID during CALC and DONE.
    xfer(8'd255, 8'd0, 8'd51, 8'd0, 8'd1, 8'd0, 5);

    // Reset on the 4th CALC cycle discards the in-flight result.
    XIN = 8'd250; B = 8'd10; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    tick(); tick(); tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("abort_valid", ov[0], 0);
    check("abort_in_ready", ir[0], 1);
    check("abort_a", ao[0], 0);
    check("abort_rem", rm[0], 0);
    check("abort_exact", ex[0], 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ov[0]) seen++;
    end
    check("abort_no_result", seen, 0);
    xfer(8'd32, 8'd3, 8'd7, 8'd0, 8'd0, 8'd35, 0);

    for (int i = 0; i < 16; i++) begin
      x = 8'($urandom);
      b = 8'($urandom_range(0, 255));
      s = x + b;
      xfer(x, b, s / 8'd5, s % 8'd5, s / 8'd255, s % 8'd255, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
